// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 demux sequencing controller.
// Optional feature macro used by this slice: DEMUX_DROP_CNT_EN (saturating drop counter).
package demux_pkg;

    // Output fan-out and select width of the demux datapath.
    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;

    // Width of the hold-timeout counter and of the drop counter.
    localparam int CNT_W   = 8;

    // Controller states: IDLE waits for a beat, HOLD presents it to one lane.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Routing mode, sampled when a beat is accepted.
    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    typedef logic [SEL_W-1:0] lane_t;

    // Decode a lane index into the one-hot per-lane valid vector.
    function automatic logic [NUM_OUT-1:0] lane_onehot(input lane_t lane);
        logic [NUM_OUT-1:0] oh;
        oh       = '0;
        oh[lane] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/demux_timeout_cnt.sv
// Hold-timeout counter: cleared when a beat is accepted, counts every HOLD
// cycle without target-lane ready, and flags expiry on the last waiting cycle.
// TIMEOUT = 0 disables expiry entirely (the counter still runs but saturates).
module demux_timeout_cnt
    import demux_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    // Count value on which a still-waiting beat is given up.
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;

    // Counter register: clear wins over increment; saturate so it never wraps.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
        end else if (en && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Expiry only in a counting cycle (no ready), so a ready in the last cycle wins.
    always_comb begin
        expire = (TIMEOUT != 0) && en && (count_q == LAST);
    end

endmodule

// File: rtl/demux_1x4_ctrl.sv
// Sequencing controller for the 1-to-4 demux datapath.
// A beat accepted in IDLE is held in HOLD on one lane (addressed or
// round-robin) until that lane is ready or the hold timeout drops it.
// Optional feature macro: DEMUX_DROP_CNT_EN enables the saturating drop_cnt.
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high; valid, once raised, holds its payload stable until that
// edge (or, on the output side, until the timeout drops the beat); ready may
// be raised or lowered freely and never depends on valid of the same side.
module demux_1x4_ctrl
    import demux_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SEL_W-1:0]   in_dest,
    input  logic               mode,
    output logic               s0,
    output logic               s1,
    output logic [DATA_W-1:0]  out_data,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic               drop,
    output logic [CNT_W-1:0]   drop_cnt
);

    state_e            state_q;
    state_e            state_d;
    lane_t             dest_q;
    lane_t             rr_ptr_q;
    logic              rr_beat_q;
    logic [DATA_W-1:0] data_q;
    logic              drop_q;

    logic accept;
    logic deliver;
    logic waiting;
    logic expire;
    logic hold_done;

    // Handshake events derived from the current state and lane readiness.
    always_comb begin
        accept    = in_valid && in_ready;
        deliver   = (state_q == ST_HOLD) && out_ready[dest_q];
        waiting   = (state_q == ST_HOLD) && !out_ready[dest_q];
        hold_done = deliver || expire;
    end

    demux_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (waiting),
        .expire (expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept moves to HOLD, delivery or expiry returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs: input ready in IDLE, one-hot lane valid in HOLD.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = '0;
        case (state_q)
            ST_IDLE: in_ready  = !rst;
            ST_HOLD: out_valid = lane_onehot(dest_q);
            default: begin
                in_ready  = 1'b0;
                out_valid = '0;
            end
        endcase
    end

    // Beat capture: payload, destination and routing mode are frozen at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            dest_q    <= '0;
            rr_beat_q <= 1'b0;
        end else if (accept) begin
            data_q    <= in_data;
            dest_q    <= (mode == MODE_RR) ? rr_ptr_q : in_dest;
            rr_beat_q <= (mode == MODE_RR);
        end
    end

    // Round-robin pointer: advances once a round-robin beat leaves HOLD either way.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (hold_done && rr_beat_q) begin
            rr_ptr_q <= rr_ptr_q + 1'b1;
        end
    end

    // Drop pulse: registered so it appears in the cycle after the last hold cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= expire;
        end
    end

`ifdef DEMUX_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt_q;

    // Saturating count of timeout drops, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (expire && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

    assign {s1, s0}  = dest_q;
    assign out_data  = data_q;
    assign drop      = drop_q;

endmodule
